// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one memory port between fetch and data requesters
// Data wins by default; a starvation counter forces fetch, and a timeout aborts hung accesses.

module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_GNT, S_RESP} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port, 0 = fetch port
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= 8'd0;
      to_cnt_q     <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (d_req && !(if_req && starve_cnt_q == STARVE_LIM)) begin
          owner_d     = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = S_GNT;
          if (if_req && starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
        end else if (if_req) begin
          owner_d      = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = 32'd0;
          starve_cnt_d = 8'd0;
          state_d      = S_GNT;
        end
      end
      S_GNT: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (mem_ack) begin
          // A store completing leaves the last load data visible on d_rdata.
          if (owner_q) begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          bus_err_d = 1'b1;
          if (owner_q) d_rdata_d = 32'd0;
          else         if_rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        to_cnt_d = 8'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_req  = (state_q == S_GNT);
    if_ready = (state_q == S_RESP) && !owner_q;
    d_ready  = (state_q == S_RESP) && owner_q;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
